// File: rtl/fetch_pkg.sv
// Shared fetch types and the absolute branch target table.
// Program builds edit lut_init() to place their bl targets.
package fetch_pkg;
    localparam int LUT_A = 10;
    localparam int LUT_L = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t;

    typedef logic [2**LUT_L-1:0][LUT_A-1:0] lut_t;

    function automatic lut_t lut_init();
        lut_t t;
        t    = '0;
        t[1] = LUT_A'(15);
        return t;
    endfunction

    localparam lut_t BRANCH_LUT = lut_init();
endpackage

// File: rtl/branch_lut.sv
// Combinational index -> absolute target lookup for bl branches.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int A = 10,
    parameter int L = 4
) (
    input  logic [L-1:0] idx,
    output logic [A-1:0] target
);

    assign target = A'(BRANCH_LUT[idx]);

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencer feeding the instruction ROM: start/halt handshake,
// relative and LUT branches, and a saturating RUN-cycle counter.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int A  = 10,
    parameter int OW = 6,
    parameter int L  = 4,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Halt,
    input  logic          BranchEn,
    input  logic          BranchMode,
    input  logic [OW-1:0] BranchField,
    output logic [A-1:0]  InstAddress,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    fetch_state_t  state, state_nxt;
    logic [A-1:0]  pc, pc_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [A-1:0]  lut_target;
    logic [A-1:0]  rel_target;

    branch_lut #(.A(A), .L(L)) u_lut (
        .idx    (BranchField[L-1:0]),
        .target (lut_target)
    );

    // Sign-extended offset; the add wraps modulo 2**A in both directions.
    assign rel_target = pc + A'($signed(BranchField));

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            pc    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = RUN;
            RUN:     if (Halt)  state_nxt = DONE;
            DONE:    if (Start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Next PC and counter; halt outranks branch so a halting branch never moves the PC.
    always_comb begin
        pc_nxt  = pc;
        cnt_nxt = cnt;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    pc_nxt  = '0;
                    cnt_nxt = '0;
                end
            end
            RUN: begin
                cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
                if (Halt)
                    pc_nxt = pc;
                else if (BranchEn)
                    pc_nxt = BranchMode ? lut_target : rel_target;
                else
                    pc_nxt = pc + 1'b1;
            end
            default: begin
                pc_nxt  = '0;
                cnt_nxt = '0;
            end
        endcase
    end

    always_comb begin
        Running     = (state == RUN);
        Done        = (state == DONE);
        InstAddress = pc;
        CycleCount  = cnt;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: the bench plays the decode stage.
module tb_fetch_ctrl;
    logic        Clk = 0;
    logic        Reset, Start, Halt, BranchEn, BranchMode;
    logic [5:0]  BranchField;
    logic [9:0]  InstAddress;
    logic        Running, Done;
    logic [15:0] CycleCount;

    int n_chk = 0;
    int n_fail = 0;

    fetch_ctrl #(.A(10), .OW(6), .L(4), .CW(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt),
        .BranchEn(BranchEn), .BranchMode(BranchMode), .BranchField(BranchField),
        .InstAddress(InstAddress), .Running(Running), .Done(Done),
        .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int pc, input int run, input int dn, input int cnt);
        chk({tag, ".pc"}, int'(InstAddress), pc);
        chk({tag, ".run"}, int'(Running), run);
        chk({tag, ".done"}, int'(Done), dn);
        chk({tag, ".cnt"}, int'(CycleCount), cnt);
    endtask

    task automatic br(input logic mode, input logic [5:0] f);
        BranchEn = 1; BranchMode = mode; BranchField = f;
        step();
        BranchEn = 0; BranchMode = 0; BranchField = '0;
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 1100 && int'(InstAddress) != target; k++) step();
        chk("run_to", int'(InstAddress), target);
    endtask

    initial begin
        Reset = 1; Start = 0; Halt = 0; BranchEn = 0; BranchMode = 0; BranchField = '0;
        #1;
        chk_all("rst", 0, 0, 0, 0);
        step();
        Reset = 0;
        for (int i = 0; i < 5; i++) begin
            Halt = 1; BranchEn = 1;   // ignored in IDLE
            step();
            chk_all("idle", 0, 0, 0, 0);
        end
        Halt = 0; BranchEn = 0;

        // straight-line run, halt at 7; Start mid-run must be ignored
        Start = 1; step(); Start = 0;
        chk_all("start", 0, 1, 0, 0);
        for (int e = 0; e < 8; e++) begin
            chk("seq.pc", int'(InstAddress), e);
            Halt  = (e == 7);
            Start = (e == 3);
            step();
        end
        Halt = 0; Start = 0;
        chk_all("halt", 7, 0, 1, 8);
        step(); step();
        chk_all("done_hold", 7, 0, 1, 8);

        // restart from DONE
        Start = 1; step(); Start = 0;
        chk_all("restart", 0, 1, 0, 0);

        // relative branches
        run_to(5);
        br(0, 6'b111100);
        chk("rel_neg", int'(InstAddress), 1);
        run_to(5);
        br(0, 6'b000000);
        chk("spin1", int'(InstAddress), 5);
        br(0, 6'b000000);
        chk("spin2", int'(InstAddress), 5);
        step();
        chk("after_spin", int'(InstAddress), 6);
        chk("cnt13", int'(CycleCount), 13);

        // LUT branches; upper field bits are ignored
        run_to(14);
        br(1, 6'b000001);
        chk("lut1", int'(InstAddress), 15);
        br(0, 6'b111111);
        chk("rel_m1", int'(InstAddress), 14);
        br(1, 6'b110001);
        chk("lut_hi", int'(InstAddress), 15);
        br(1, 6'b000000);
        chk("lut0", int'(InstAddress), 0);

        // wrap both ways
        br(0, 6'b111111);
        chk("wrap_dn", int'(InstAddress), 1023);
        step();
        chk("wrap_up", int'(InstAddress), 0);
        run_to(2);
        br(0, 6'b111100);
        chk("wrap_rel", int'(InstAddress), 1022);

        // halt beats branch
        run_to(3);
        Halt = 1; BranchEn = 1; BranchMode = 0; BranchField = 6'b111100;
        step();
        Halt = 0; BranchEn = 0; BranchField = '0;
        chk("hb.pc", int'(InstAddress), 3);
        chk("hb.done", int'(Done), 1);
        chk("hb.run", int'(Running), 0);

        // async reset mid-cycle in RUN
        Start = 1; step(); Start = 0;
        run_to(9);
        #2 Reset = 1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        step();
        Reset = 0;
        step();
        chk_all("post_rst", 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
